// File: rtl/addition_stage4_normalizer.sv
// Final stage of the floating-point adder: renormalises the raw stage3 sum,
// adjusting the exponent and flagging zero, overflow and underflow results.
module addition_stage4_normalizer #(
    parameter int MENT_WIDTH = 23,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [MENT_WIDTH+1:0]  mant_in,
    input  logic [EXP_WIDTH-1:0]   exp_in,
    input  logic                   sign_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   sign_out,
    output logic [EXP_WIDTH-1:0]   exp_out,
    output logic [MENT_WIDTH-1:0]  mant_out,
    output logic                   zero_out,
    output logic                   overflow_out,
    output logic                   underflow_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [EXP_WIDTH-1:0] EXP_ONE     = EXP_WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] EXP_ZERO    = {EXP_WIDTH{1'b0}};
    localparam logic [EXP_WIDTH-1:0] EXP_ALL     = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0] EXP_OVF_LIM = ~EXP_WIDTH'(1);

    state_t                  r_state;
    logic [MENT_WIDTH:0]     r_mant;   // hidden bit kept at the top while normalising
    logic [EXP_WIDTH-1:0]    r_exp;
    logic                    r_sign;
    logic                    r_valid;
    logic                    r_zero;
    logic                    r_ovf;
    logic                    r_unf;

    logic                    w_can_accept;
    logic                    w_load;
    state_t                  w_acc_state;
    logic [MENT_WIDTH:0]     w_acc_mant;
    logic [EXP_WIDTH-1:0]    w_acc_exp;
    logic                    w_acc_zero;
    logic                    w_acc_ovf;
    logic [MENT_WIDTH:0]     w_shift_mant;

    assign w_can_accept = (r_state == IDLE) || ((r_state == HOLD) && ready_in);
    assign w_load       = valid_in && w_can_accept;
    assign w_shift_mant = {r_mant[MENT_WIDTH-1:0], 1'b0};

    assign ready_out     = rst_n_in && w_can_accept;
    assign valid_out     = r_valid;
    assign sign_out      = r_sign;
    assign exp_out       = r_exp;
    assign mant_out      = r_mant[MENT_WIDTH-1:0];
    assign zero_out      = r_zero;
    assign overflow_out  = r_ovf;
    assign underflow_out = r_unf;

    // Classify an incoming operand and compute its first-cycle result.
    always_comb begin
        w_acc_state = HOLD;
        w_acc_mant  = mant_in[MENT_WIDTH:0];
        w_acc_exp   = exp_in;
        w_acc_zero  = 1'b0;
        w_acc_ovf   = 1'b0;
        if (mant_in == {(MENT_WIDTH+2){1'b0}}) begin
            w_acc_mant = {(MENT_WIDTH+1){1'b0}};
            w_acc_exp  = EXP_ZERO;
            w_acc_zero = 1'b1;
        end else if (mant_in[MENT_WIDTH+1]) begin
            if (exp_in >= EXP_OVF_LIM) begin
                w_acc_mant = {(MENT_WIDTH+1){1'b0}};
                w_acc_exp  = EXP_ALL;
                w_acc_ovf  = 1'b1;
            end else begin
                w_acc_mant = mant_in[MENT_WIDTH+1:1];
                w_acc_exp  = exp_in + EXP_ONE;
            end
        end else if (mant_in[MENT_WIDTH]) begin
            w_acc_state = HOLD;
        end else begin
            w_acc_state = NORM;
        end
    end

    // Control FSM and result registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
            r_mant  <= {(MENT_WIDTH+1){1'b0}};
            r_exp   <= EXP_ZERO;
            r_sign  <= 1'b0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_load) begin
            r_state <= w_acc_state;
            r_mant  <= w_acc_mant;
            r_exp   <= w_acc_exp;
            r_sign  <= sign_in;
            r_valid <= (w_acc_state == HOLD);
            r_zero  <= w_acc_zero;
            r_ovf   <= w_acc_ovf;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                NORM: begin
                    // Exponent cannot absorb another shift: flush to zero.
                    if (r_exp <= EXP_ONE) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                        r_mant  <= {(MENT_WIDTH+1){1'b0}};
                        r_exp   <= EXP_ZERO;
                        r_unf   <= 1'b1;
                    end else begin
                        r_mant <= w_shift_mant;
                        r_exp  <= r_exp - EXP_ONE;
                        if (w_shift_mant[MENT_WIDTH]) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                HOLD: begin
                    if (ready_in) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                IDLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addition_stage4_normalizer.sv
// Directed and randomised checks of addition_stage4_normalizer against an
// arithmetic reference model (MENT_WIDTH=23, EXP_WIDTH=8).
module tb_addition_stage4_normalizer;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [24:0] mant_in = 25'd0;
    logic [7:0]  exp_in = 8'd0;
    logic        sign_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [22:0] mant_out;
    logic        zero_out;
    logic        overflow_out;
    logic        underflow_out;

    int n_asserts = 0;
    int n_fail    = 0;

    addition_stage4_normalizer #(.MENT_WIDTH(23), .EXP_WIDTH(8)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .mant_in       (mant_in),
        .exp_in        (exp_in),
        .sign_in       (sign_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .sign_out      (sign_out),
        .exp_out       (exp_out),
        .mant_out      (mant_out),
        .zero_out      (zero_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: value-level normalisation with truncation; latency counted in
    // edges from the accept edge up to the edge that raises valid_out.
    task automatic model(input logic [24:0] m, input logic [7:0] e,
                         output logic [7:0] xe, output logic [22:0] xm,
                         output logic xz, output logic xo, output logic xu,
                         output int lat);
        longint mv = longint'(m);
        longint ev = longint'(e);
        longint hid = 64'd8388608;
        longint car = 64'd16777216;
        int k = 0;
        xz = 1'b0; xo = 1'b0; xu = 1'b0; lat = 1;
        xe = e; xm = 23'd0;
        if (mv == 0) begin
            xe = 8'd0; xz = 1'b1;
        end else if (mv >= car) begin
            if (ev >= 254) begin
                xe = 8'd255; xo = 1'b1;
            end else begin
                xe = 8'(ev + 1);
                xm = 23'((mv / 2) % hid);
            end
        end else if (mv >= hid) begin
            xm = 23'(mv % hid);
        end else begin
            while ((mv << k) < hid) k++;
            if (ev <= k) begin
                xe = 8'd0; xu = 1'b1;
                lat = (ev >= 1) ? int'(ev) + 1 : 2;
            end else begin
                xe = 8'(ev - k);
                xm = 23'((mv << k) % hid);
                lat = 1 + k;
            end
        end
    endtask

    // Present one operand from IDLE and wait for its result to appear in HOLD.
    task automatic start_and_wait(input logic [24:0] m, input logic [7:0] e, input logic s);
        logic [7:0]  xe;
        logic [22:0] xm;
        logic        xz, xo, xu;
        int          lat;
        int          n;
        logic        rdy_seen;
        model(m, e, xe, xm, xz, xo, xu, lat);
        chk("ready_idle", 32'(ready_out), 32'd1);
        mant_in = m; exp_in = e; sign_in = s; valid_in = 1'b1; ready_in = 1'b0;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        mant_in = 25'($urandom); exp_in = 8'($urandom); sign_in = 1'($urandom);
        n = 1;
        rdy_seen = 1'b0;
        while (valid_out !== 1'b1 && n < 60) begin
            rdy_seen = rdy_seen | ready_out;
            @(posedge clk_in); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("ready_busy", 32'(rdy_seen), 32'd0);
        chk("exp", 32'(exp_out), 32'(xe));
        chk("mant", 32'(mant_out), 32'(xm));
        chk("sign", 32'(sign_out), 32'(s));
        chk("flags", {29'd0, zero_out, overflow_out, underflow_out}, {29'd0, xz, xo, xu});
    endtask

    task automatic release_result();
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        ready_in = 1'b0;
        chk("idle_valid", 32'(valid_out), 32'd0);
        chk("idle_ready", 32'(ready_out), 32'd1);
    endtask

    task automatic do_op(input logic [24:0] m, input logic [7:0] e, input logic s);
        start_and_wait(m, e, s);
        release_result();
    endtask

    initial begin
        logic [24:0] rm;
        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_outs", {22'd0, valid_out, sign_out, exp_out},  32'd0);
        chk("rst_mant", {9'd0, mant_out}, 32'd0);
        chk("rst_flags", {29'd0, zero_out, overflow_out, underflow_out}, 32'd0);
        rst_n_in = 1'b1;
        #1;
        chk("ready_after_rst", 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;

        // Directed corner cases
        do_op(25'h0800000, 8'd127, 1'b0);
        do_op(25'h1800000, 8'd127, 1'b1);
        do_op(25'h0100000, 8'd130, 1'b0);
        do_op(25'h0000001, 8'd5,   1'b1);
        do_op(25'h1000000, 8'd254, 1'b0);
        do_op(25'h1FFFFFF, 8'd253, 1'b0);
        do_op(25'h0000000, 8'd77,  1'b1);
        do_op(25'h0400000, 8'd1,   1'b0);
        do_op(25'h0400000, 8'd2,   1'b0);
        do_op(25'h0000001, 8'd24,  1'b1);

        // Backpressure in HOLD, then back-to-back accept
        start_and_wait(25'h0800000, 8'd127, 1'b1);
        repeat (5) begin
            @(posedge clk_in); #1;
            chk("hold_valid", 32'(valid_out), 32'd1);
            chk("hold_exp", 32'(exp_out), 32'd127);
            chk("hold_mant", 32'(mant_out), 32'd0);
            chk("hold_sign", 32'(sign_out), 32'd1);
            chk("hold_ready", 32'(ready_out), 32'd0);
        end
        mant_in = 25'h1800000; exp_in = 8'd127; sign_in = 1'b0;
        valid_in = 1'b1; ready_in = 1'b1;
        #1;
        chk("b2b_ready", 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;
        valid_in = 1'b0; ready_in = 1'b0;
        chk("b2b_valid", 32'(valid_out), 32'd1);
        chk("b2b_exp", 32'(exp_out), 32'd128);
        chk("b2b_mant", 32'(mant_out), 32'h400000);
        chk("b2b_sign", 32'(sign_out), 32'd0);
        release_result();

        // Reset during NORM discards the operation
        mant_in = 25'h0000100; exp_in = 8'd127; sign_in = 1'b1; valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("norm_valid", 32'(valid_out), 32'd0);
        chk("norm_ready", 32'(ready_out), 32'd0);
        rst_n_in = 1'b0;
        @(posedge clk_in); #1;
        chk("midrst_outs", {22'd0, valid_out, sign_out, exp_out}, 32'd0);
        chk("midrst_mant", {9'd0, mant_out}, 32'd0);
        chk("midrst_flags", {29'd0, zero_out, overflow_out, underflow_out}, 32'd0);
        chk("midrst_ready", 32'(ready_out), 32'd0);
        rst_n_in = 1'b1;
        #1;
        chk("midrst_ready_rel", 32'(ready_out), 32'd1);
        @(posedge clk_in); #1;
        chk("midrst_no_resume", 32'(valid_out), 32'd0);

        // Randomised operands across all classification paths
        for (int i = 0; i < 150; i++) begin
            rm = 25'($urandom) >> $urandom_range(0, 25);
            do_op(rm, 8'($urandom_range(0, 255)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/addition_stage4_normalizer.md
ADDITION_STAGE4_NORMALIZER -- requirements
Module: addition_stage4_normalizer

Interface
REQ-001 SHALL have parameter MENT_WIDTH, default 23, the stored mantissa width without the hidden bit.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, the biased exponent width.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port mant_in, input, MENT_WIDTH+2 bits: raw sum from stage3; bit MENT_WIDTH+1 = carry, bit MENT_WIDTH = hidden-bit position.
REQ-006 SHALL have port exp_in, input, EXP_WIDTH bits: larger operand exponent from stage1.
REQ-007 SHALL have port sign_in, input, 1 bit: result sign.
REQ-008 SHALL have port valid_in, input, 1 bit: upstream data valid.
REQ-009 SHALL have port ready_out, output, 1 bit: block can accept.
REQ-010 SHALL have port valid_out, output, 1 bit: result valid.
REQ-011 SHALL have port ready_in, input, 1 bit: downstream can accept.
REQ-012 SHALL have port sign_out, output, 1 bit: result sign.
REQ-013 SHALL have port exp_out, output, EXP_WIDTH bits: normalized biased exponent.
REQ-014 SHALL have port mant_out, output, MENT_WIDTH bits: normalized mantissa, hidden bit removed.
REQ-015 SHALL have ports zero_out, overflow_out and underflow_out, each output, 1 bit: status flags.

Function
REQ-016 SHALL implement FSM states IDLE, NORM and HOLD.
REQ-017 SHALL drive ready_out = (state==IDLE) or (state==HOLD and ready_in), and SHALL drive ready_out 0 while rst_n_in is low.
REQ-018 SHALL accept on a rising edge with valid_in and ready_out both high, latching mant_in, exp_in and sign_in and clearing all three flags.
REQ-019 On accept with mant_in==0: exp_out=0, mant_out=0, zero_out=1, next state HOLD.
REQ-020 On accept with carry bit set: mantissa shifted right 1 (LSB truncated), exp+1, next state HOLD; if exp_in >= 2^EXP_WIDTH-2, instead exp_out=all-ones, mant_out=0, overflow_out=1.
REQ-021 On accept with carry clear and hidden bit set: pass through unchanged, next state HOLD.
REQ-022 On accept otherwise: next state NORM.
REQ-023 In NORM, if exp_reg <= 1, SHALL flush: exp_out=0, mant_out=0, underflow_out=1, next state HOLD.
REQ-024 In NORM, otherwise, each edge SHALL shift the mantissa left by 1 (zero fill) and decrement exp by 1, and SHALL enter HOLD on the edge where the hidden bit becomes 1.
REQ-025 Latency: valid_out high after the accept edge for the REQ-019/020/021 cases; after k further edges for k leading zeros below the hidden bit; k <= MENT_WIDTH.
REQ-026 valid_out SHALL be 1 only in HOLD; outputs SHALL stay stable in HOLD while ready_in is low.
REQ-027 In HOLD with ready_in high: with valid_in high, a new operand SHALL be accepted on the same edge (back-to-back); otherwise the next state SHALL be IDLE.
REQ-028 Rounding SHALL be truncation; no sticky or guard bits.
REQ-029 Inputs in IDLE without valid_in, and in NORM, SHALL be ignored.

Reset
REQ-030 With rst_n_in low at an edge: state=IDLE; valid_out, sign_out, exp_out, mant_out, zero_out, overflow_out and underflow_out SHALL all be 0, and any in-flight operation SHALL be discarded.
REQ-031 ready_out SHALL be 1 on the first cycle after rst_n_in returns high.

Verification (MENT_WIDTH=23, EXP_WIDTH=8)
REQ-032 mant_in=25'h0800000, exp_in=127 -> valid_out 1 edge after accept, exp_out=127, mant_out=0, flags 0.
REQ-033 mant_in=25'h1800000, exp_in=127 -> exp_out=128, mant_out=23'h400000, 1-edge latency.
REQ-034 mant_in=25'h0100000, exp_in=130 -> valid_out after 4 edges, exp_out=127, mant_out=0.
REQ-035 mant_in=25'h0000001, exp_in=5 -> underflow_out=1, exp_out=0, mant_out=0; and mant_in=25'h1000000, exp_in=254 -> overflow_out=1, exp_out=255, mant_out=0.
REQ-036 Hold ready_in=0 for 5 cycles in HOLD -> outputs unchanged and ready_out=0; then ready_in=1 with valid_in=1 -> new operand accepted on the same edge.
REQ-037 Drop rst_n_in during NORM (mant_in=25'h0000100) -> next cycle state IDLE, valid_out=0, all outputs 0.
